// File: rtl/riscv_pkg.sv
// Shared opcode, field-layout and encoder-state definitions for the 16-bit instruction set.
// Also holds the pure field-packing helpers used by instr_encoder.
package riscv_pkg;

  typedef enum logic [2:0] {
    R_OP  = 3'd0,
    I_OP  = 3'd1,
    L_OP  = 3'd2,
    S_OP  = 3'd3,
    B_OP  = 3'd4,
    J_OP  = 3'd5,
    JR_OP = 3'd6
  } opcode_t;

  localparam int unsigned RD_LSB     = 3;
  localparam int unsigned RS1_LSB    = 6;
  localparam int unsigned RS2_LSB    = 9;
  localparam int unsigned FUNC_LSB   = 9;
  localparam int unsigned IMM4_LSB   = 12;
  localparam int unsigned J_IMM_LSB  = 6;
  localparam int unsigned JR_IMM_LSB = 10;

  localparam int unsigned IMM_W_IBS = 4;
  localparam int unsigned IMM_W_J   = 10;
  localparam int unsigned IMM_W_JR  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } encoder_state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [3:0]  func4;
    logic [2:0]  func2;
    logic [15:0] imm;
  } field_bundle_t;

  function automatic logic op_valid(logic [2:0] op);
    logic ok;
    case (op)
      R_OP, I_OP, L_OP, S_OP, B_OP, J_OP, JR_OP: ok = 1'b1;
      default:                                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True when imm, read as signed, lies in [-2**(w-1), 2**(w-1)-1].
  function automatic logic fits_signed(logic [15:0] imm, int unsigned w);
    logic signed [16:0] v;
    logic signed [16:0] lim;
    v   = 17'($signed(imm));
    lim = 17'sd1 <<< (w - 1);
    return (v >= -lim) && (v < lim);
  endfunction

  function automatic logic [15:0] encode(field_bundle_t b);
    logic [15:0] w;
    w      = '0;
    w[2:0] = b.op;
    case (b.op)
      R_OP: begin
        w[RD_LSB +: 3]   = b.rd;
        w[RS1_LSB +: 3]  = b.rs1;
        w[RS2_LSB +: 3]  = b.rs2;
        w[IMM4_LSB +: 4] = b.func4;
      end
      I_OP, L_OP: begin
        w[RD_LSB +: 3]           = b.rd;
        w[RS1_LSB +: 3]          = b.rs1;
        w[FUNC_LSB +: 3]         = b.func2;
        w[IMM4_LSB +: IMM_W_IBS] = b.imm[IMM_W_IBS-1:0];
      end
      S_OP, B_OP: begin
        w[RD_LSB +: 3]           = b.rs2;
        w[RS1_LSB +: 3]          = b.rs1;
        w[FUNC_LSB +: 3]         = b.func2;
        w[IMM4_LSB +: IMM_W_IBS] = b.imm[IMM_W_IBS-1:0];
      end
      J_OP: begin
        w[RD_LSB +: 3]           = b.rd;
        w[J_IMM_LSB +: IMM_W_J]  = b.imm[IMM_W_J-1:0];
      end
      JR_OP: begin
        w[RD_LSB +: 3]           = b.rd;
        w[RS1_LSB +: 3]          = b.rs1;
        w[JR_IMM_LSB +: IMM_W_JR] = b.imm[IMM_W_JR-1:0];
      end
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO for encoded instruction words; DEPTH must be a power of two >= 2.
// Push is ignored when full, pop is ignored when empty; reset flushes the pointers.
module instr_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded field bundles into 16-bit instruction words and streams them to imem.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_last_i,
  input  logic [2:0]        op_i,
  input  logic [2:0]        rd_i,
  input  logic [2:0]        rs1_i,
  input  logic [2:0]        rs2_i,
  input  logic [3:0]        func4_i,
  input  logic [2:0]        func2_i,
  input  logic [15:0]       imm_i,
  output logic              wr_valid_o,
  input  logic              wr_ready_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [15:0]       wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] words_o
);

  encoder_state_t    state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] words_q;
  logic              err_q;
  logic              done_q;

  field_bundle_t     bundle;
  logic [15:0]       enc_word;
  logic              imm_ok;
  logic              keep;
  logic              accept;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;

  assign bundle = '{op: op_i, rd: rd_i, rs1: rs1_i, rs2: rs2_i,
                    func4: func4_i, func2: func2_i, imm: imm_i};
  assign enc_word = encode(bundle);

  always_comb begin
    imm_ok = 1'b1;
`ifdef IMM_RANGE_CHECK_EN
    case (op_i)
      I_OP, L_OP, S_OP, B_OP: imm_ok = fits_signed(imm_i, IMM_W_IBS);
      J_OP:                   imm_ok = fits_signed(imm_i, IMM_W_J);
      JR_OP:                  imm_ok = fits_signed(imm_i, IMM_W_JR);
      default:                imm_ok = 1'b1;
    endcase
`endif
  end

  assign keep       = op_valid(op_i) && imm_ok;
  assign in_ready_o = (state_q == LOAD) && !fifo_full;
  assign accept     = in_valid_i && in_ready_o;
  assign fifo_push  = accept && keep;
  assign fifo_pop   = !fifo_empty && wr_ready_i;

  instr_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (enc_word),
    .pop_i   (fifo_pop),
    .rdata_o (wr_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The FIFO is always empty in IDLE, so a start never collides with a pending pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (fifo_pop) begin
        addr_q  <= addr_q + 1'b1;
        words_q <= words_q + 1'b1;
      end
      if (accept && !keep) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= LOAD;
            addr_q  <= base_addr_i;
            words_q <= '0;
            err_q   <= 1'b0;
          end
        end
        LOAD: begin
          if (accept && in_last_i) state_q <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_valid_o = !fifo_empty;
  assign wr_addr_o  = addr_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign words_o    = words_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected writes are queued when a bundle is accepted
// and compared by a monitor when the imem write handshake completes.
module tb_instr_encoder;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [7:0]  base_addr_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        in_last_i;
  logic [2:0]  op_i, rd_i, rs1_i, rs2_i, func2_i;
  logic [3:0]  func4_i;
  logic [15:0] imm_i;
  logic        wr_valid_o;
  logic        wr_ready_i;
  logic [7:0]  wr_addr_o;
  logic [15:0] wr_data_o;
  logic        busy_o, done_o, err_o;
  logic [7:0]  words_o;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_last_i(in_last_i),
    .op_i(op_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .func4_i(func4_i), .func2_i(func2_i), .imm_i(imm_i),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .words_o(words_o)
  );

  typedef struct { logic [7:0] addr; logic [15:0] data; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_addr;
  logic [7:0] exp_words;

  // Independent reference packing written as per-format concatenations.
  function automatic logic [15:0] ref_enc(logic [2:0] op, logic [2:0] rd, logic [2:0] rs1,
                                          logic [2:0] rs2, logic [3:0] f4, logic [2:0] f2,
                                          logic [15:0] imm);
    case (op)
      R_OP:        return {f4, rs2, rs1, rd, op};
      I_OP, L_OP:  return {imm[3:0], f2, rs1, rd, op};
      S_OP, B_OP:  return {imm[3:0], f2, rs1, rs2, op};
      J_OP:        return {imm[9:0], rd, op};
      JR_OP:       return {imm[5:0], rs1, rd, op};
      default:     return 16'h0000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && wr_valid_o && wr_ready_i) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%h data=%h, no write expected", wr_addr_o, wr_data_o);
      end else begin
        mon_e = sbq.pop_front();
        if (wr_addr_o !== mon_e.addr || wr_data_o !== mon_e.data) begin
          errors++;
          $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                   wr_addr_o, wr_data_o, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] base);
    start_i     = 1'b1;
    base_addr_i = base;
    tick();
    start_i   = 1'b0;
    exp_addr  = base;
    exp_words = 8'd0;
  endtask

  // Offers one bundle until accepted; a written bundle queues its expected address and data.
  task automatic send(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic [3:0] f4, input logic [2:0] f2,
                      input logic [15:0] imm, input logic last, input bit wr,
                      input logic [15:0] data);
    bit acc;
    exp_t e;
    acc = 1'b0;
    op_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
    func4_i = f4; func2_i = f2; imm_i = imm; in_last_i = last;
    in_valid_i = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready_o) begin
        acc = 1'b1;
        if (wr) begin
          e.addr = exp_addr;
          e.data = data;
          sbq.push_back(e);
          exp_addr  = exp_addr + 8'd1;
          exp_words = exp_words + 8'd1;
        end
        tick();
        break;
      end
      tick();
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: in_ready_o never rose for op=%0d", op);
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({wr_valid_o, in_ready_o, busy_o, done_o, err_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {wr_valid_o, in_ready_o, busy_o, done_o, err_o});
    end
    checks++;
    if (wr_addr_o !== 8'h00 || words_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_counters: got addr=%h words=%h expected 00 00", wr_addr_o, words_o);
    end
    tick();
  endtask

  task automatic test_single_r();
    bit seen;
    do_start(8'h10);
    send(R_OP, 3'd1, 3'd2, 3'd3, 4'hA, 3'd0, 16'h0, 1'b1, 1'b1, 16'hA688 | 16'(R_OP));
    wait_done(seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL single_done: got no done_o pulse, expected one"); end
    @(negedge clk);
    checks++;
    if (words_o !== 8'd1 || done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_post: got words=%0d done=%b busy=%b expected 1 0 0", words_o, done_o, busy_o);
    end
    tick();
  endtask

  task automatic test_jump_formats();
    bit seen;
    do_start(8'h20);
    send(J_OP, 3'd7, 3'd0, 3'd0, 4'h0, 3'd0, 16'hFFFF, 1'b0, 1'b1, 16'hFFF8 | 16'(J_OP));
    send(JR_OP, 3'd0, 3'd1, 3'd0, 4'h0, 3'd0, 16'hFFE0, 1'b1, 1'b1, 16'h8040 | 16'(JR_OP));
    wait_done(seen);
    checks++;
    if (!seen || words_o !== 8'd2 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL jump_done: got seen=%b words=%0d err=%b expected 1 2 0", seen, words_o, err_o);
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    logic [2:0] ops[6] = '{R_OP, I_OP, S_OP, J_OP, L_OP, B_OP};
    do_start(8'h40);
    wr_ready_i = 1'b0;
    for (int k = 0; k < 4; k++)
      send(ops[k], 3'(k), 3'(k + 1), 3'(k + 2), 4'(k + 5), 3'(k), 16'(k * 3),
           1'b0, 1'b1, ref_enc(ops[k], 3'(k), 3'(k + 1), 3'(k + 2), 4'(k + 5), 3'(k), 16'(k * 3)));
    in_valid_i = 1'b1;
    op_i = ops[4];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready_o !== 1'b0 || wr_valid_o !== 1'b1 ||
          wr_addr_o !== sbq[0].addr || wr_data_o !== sbq[0].data) begin
        errors++;
        $display("FAIL stall_hold: got ready=%b valid=%b addr=%h data=%h expected 0 1 %h %h",
                 in_ready_o, wr_valid_o, wr_addr_o, wr_data_o, sbq[0].addr, sbq[0].data);
      end
      tick();
    end
    wr_ready_i = 1'b1;
    for (int k = 4; k < 6; k++)
      send(ops[k], 3'(k), 3'(k + 1), 3'(k + 2), 4'(k + 5), 3'(k), 16'(k * 3),
           1'(k == 5), 1'b1,
           ref_enc(ops[k], 3'(k), 3'(k + 1), 3'(k + 2), 4'(k + 5), 3'(k), 16'(k * 3)));
    wait_done(seen);
    checks++;
    if (!seen || words_o !== 8'd6 || sbq.size() != 0) begin
      errors++;
      $display("FAIL stall_drain: got seen=%b words=%0d pending=%0d expected 1 6 0",
               seen, words_o, sbq.size());
    end
  endtask

  task automatic test_wrap();
    bit seen;
    do_start(8'hFE);
    send(S_OP, 3'd0, 3'd6, 3'd5, 4'h0, 3'd2, 16'hFFFD, 1'b0, 1'b1,
         ref_enc(S_OP, 3'd0, 3'd6, 3'd5, 4'h0, 3'd2, 16'hFFFD));
    send(B_OP, 3'd0, 3'd3, 3'd4, 4'h0, 3'd1, 16'h0007, 1'b0, 1'b1,
         ref_enc(B_OP, 3'd0, 3'd3, 3'd4, 4'h0, 3'd1, 16'h0007));
    send(L_OP, 3'd2, 3'd7, 3'd0, 4'h0, 3'd5, 16'hFFF8, 1'b1, 1'b1,
         ref_enc(L_OP, 3'd2, 3'd7, 3'd0, 4'h0, 3'd5, 16'hFFF8));
    wait_done(seen);
    checks++;
    if (!seen || err_o !== 1'b0 || wr_addr_o !== 8'h01 || words_o !== 8'd3) begin
      errors++;
      $display("FAIL wrap: got seen=%b err=%b addr=%h words=%0d expected 1 0 01 3",
               seen, err_o, wr_addr_o, words_o);
    end
  endtask

  task automatic test_imm_range();
    bit seen;
    do_start(8'h50);
`ifdef IMM_RANGE_CHECK_EN
    send(I_OP, 3'd1, 3'd2, 3'd0, 4'h0, 3'd3, 16'h0008, 1'b1, 1'b0, 16'h0000);
    wait_done(seen);
    checks++;
    if (!seen || err_o !== 1'b1 || words_o !== 8'd0) begin
      errors++;
      $display("FAIL imm_range: got seen=%b err=%b words=%0d expected 1 1 0", seen, err_o, words_o);
    end
`else
    send(I_OP, 3'd1, 3'd2, 3'd0, 4'h0, 3'd3, 16'h0008, 1'b1, 1'b1,
         {4'h8, 3'd3, 3'd2, 3'd1, 3'(I_OP)});
    wait_done(seen);
    checks++;
    if (!seen || err_o !== 1'b0 || words_o !== 8'd1) begin
      errors++;
      $display("FAIL imm_trunc: got seen=%b err=%b words=%0d expected 1 0 1", seen, err_o, words_o);
    end
`endif
  endtask

  task automatic test_invalid_op();
    bit seen;
    do_start(8'h60);
    start_i = 1'b1;
    base_addr_i = 8'h99;
    tick();
    start_i = 1'b0;
    send(3'd7, 3'd1, 3'd1, 3'd1, 4'hF, 3'd1, 16'h0, 1'b0, 1'b0, 16'h0000);
    send(R_OP, 3'd4, 3'd5, 3'd6, 4'h3, 3'd0, 16'h0, 1'b0, 1'b1,
         ref_enc(R_OP, 3'd4, 3'd5, 3'd6, 4'h3, 3'd0, 16'h0));
    send(3'd7, 3'd0, 3'd0, 3'd0, 4'h0, 3'd0, 16'h0, 1'b1, 1'b0, 16'h0000);
    wait_done(seen);
    checks++;
    if (!seen || err_o !== 1'b1 || words_o !== 8'd1 || wr_addr_o !== 8'h61) begin
      errors++;
      $display("FAIL invalid_op: got seen=%b err=%b words=%0d addr=%h expected 1 1 1 61",
               seen, err_o, words_o, wr_addr_o);
    end
    do_start(8'h70);
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL err_clear: got err=%b busy=%b expected 0 1", err_o, busy_o);
    end
    tick();
    send(R_OP, 3'd0, 3'd0, 3'd0, 4'h0, 3'd0, 16'h0, 1'b1, 1'b1, 16'h0000);
    wait_done(seen);
  endtask

  task automatic test_reset_midload();
    do_start(8'h80);
    wr_ready_i = 1'b0;
    send(R_OP, 3'd1, 3'd1, 3'd1, 4'h1, 3'd0, 16'h0, 1'b0, 1'b1, 16'h0000);
    send(J_OP, 3'd2, 3'd0, 3'd0, 4'h0, 3'd0, 16'h0011, 1'b0, 1'b1, 16'h0000);
    rst_n = 1'b0;
    sbq.delete();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_valid_o !== 1'b0 || busy_o !== 1'b0 || words_o !== 8'd0 ||
        in_ready_o !== 1'b0 || wr_addr_o !== 8'h00) begin
      errors++;
      $display("FAIL midload_reset: got valid=%b busy=%b words=%0d ready=%b addr=%h expected 0 0 0 0 00",
               wr_valid_o, busy_o, words_o, in_ready_o, wr_addr_o);
    end
    tick();
    wr_ready_i = 1'b1;
    repeat (8) tick();
    checks++;
    if (busy_o !== 1'b0 || words_o !== 8'd0) begin
      errors++;
      $display("FAIL midload_quiet: got busy=%b words=%0d expected 0 0", busy_o, words_o);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; in_valid_i = 1'b0; in_last_i = 1'b0;
    op_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0; func4_i = '0; func2_i = '0; imm_i = '0;
    wr_ready_i = 1'b1; exp_addr = '0; exp_words = '0;
    tick();
    test_reset();
    test_single_r();
    test_jump_formats();
    test_backpressure();
    test_wrap();
    test_imm_range();
    test_invalid_op();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, expected completion");
    $fatal(1, "timeout");
  end

endmodule
